fetch_unit: RTL

Instruction fetch stage sitting directly in front of the program memory. Generates the byte address stream into the memory and accounts for the memory's fixed one-cycle registered read latency. Buffers returned words in a 2-entry queue and presents them to decode through a valid/ready handshake. Handles branch/jump redirects: in-flight and queued instructions are flushed, and a misaligned target halts fetch.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program-memory address, absorbs the one-cycle read
// latency and hands words to decode from a 2-entry queue with redirect/flush support.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH  = 12,
  parameter int unsigned         OPD_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_data,
  input  logic                 redirect,
  input  logic [OPD_WIDTH-1:0] redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [OPD_WIDTH-1:0] instr_pc,
  output logic                 misalign
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic                inflight_q;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic [1:0]          count_q;
  logic [31:0]         buf_data_q [2];
  logic [PC_WIDTH-1:0] buf_pc_q   [2];
  logic                misalign_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credit;

  // Only the low PC_WIDTH bits of the redirect target address memory.
  logic unused_redirect_hi;
  assign unused_redirect_hi = ^redirect_pc[OPD_WIDTH-1:PC_WIDTH];

  assign instr_valid = (count_q != 2'd0);
  assign instr       = buf_data_q[0];
  assign instr_pc    = OPD_WIDTH'(buf_pc_q[0]);
  assign imem_addr   = fetch_pc_q;
  assign misalign    = misalign_q;

  assign pop    = instr_valid && instr_ready;
  // Slots already spoken for: queued words plus the one on its way back from memory.
  assign credit = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue  = !rst && (state_q == StRun) && !redirect && (credit < 3'd2);
  assign push   = inflight_q && !redirect && (state_q == StRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_pc_q[0]   <= '0;
      buf_pc_q[1]   <= '0;
      misalign_q    <= 1'b0;
    end else if ((state_q == StRun) && redirect) begin
      // Flush: queued entries and the word returning next cycle are dropped.
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      fetch_pc_q <= redirect_pc[PC_WIDTH-1:0];
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
        state_q    <= StHalt;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + PC_WIDTH'(4);
      end
      case ({push, pop})
        2'b10: begin
          buf_data_q[count_q[0]] <= imem_data;
          buf_pc_q[count_q[0]]   <= inflight_pc_q;
          count_q                <= count_q + 2'd1;
        end
        2'b01: begin
          buf_data_q[0] <= buf_data_q[1];
          buf_pc_q[0]   <= buf_pc_q[1];
          count_q       <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf_data_q[0] <= imem_data;
            buf_pc_q[0]   <= inflight_pc_q;
          end else begin
            buf_data_q[0] <= buf_data_q[1];
            buf_pc_q[0]   <= buf_pc_q[1];
            buf_data_q[1] <= imem_data;
            buf_pc_q[1]   <= inflight_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
